// File: rtl/lfsr_word_collector.sv
// Collects the LFSR serial bit LSB-first into WIDTH-bit words and queues them
// in a small FIFO behind a valid/ready port, counting words dropped on overflow.
module lfsr_word_collector #(
   parameter int WIDTH      = 13,
   parameter int SAMPLE_DIV = 1,
   parameter int DEPTH      = 4,
   parameter int DROP_W     = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     flush,
   input  logic                     bit_in,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [DROP_W-1:0]        overflow_cnt,
   output logic                     busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(WIDTH);
   localparam logic [AW:0] CNT_ONE = 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
   logic [7:0]       div_cnt;
   logic [WIDTH-2:0] shreg;
   logic             strobe, last;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             full, push, pop, accept, drop;

   assign strobe = enable && (div_cnt == 8'(SAMPLE_DIV - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         div_cnt <= '0;
      else if (flush)
         div_cnt <= '0;
      else if (enable)
         div_cnt <= strobe ? 8'd0 : div_cnt + 8'd1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      last        = 1'b0;
      if (flush) begin
         state_nxt   = IDLE;
         bit_cnt_nxt = '0;
      end else if (strobe) begin
         last = (bit_cnt == BW'(WIDTH - 1));
         if (last) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
         end else begin
            state_nxt   = SHIFT;
            bit_cnt_nxt = bit_cnt + BW'(1);
         end
      end
   end

   // The top bit never lands in shreg: it is taken straight from bit_in on push.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         shreg <= '0;
      else if (strobe && !flush)
         for (int i = 0; i < WIDTH - 1; i++)
            if (bit_cnt == BW'(i)) shreg[i] <= bit_in;
   end

   assign busy      = (state == SHIFT);
   assign full      = (fifo_count == (AW+1)'(DEPTH));
   assign out_valid = (fifo_count != '0);
   assign out_data  = mem[rd_ptr];
   assign push      = last;
   assign pop       = out_valid && out_ready && !flush;
   assign accept    = push && (!full || pop);
   assign drop      = push && full && !pop;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= {bit_in, shreg};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({accept, pop})
            2'b10:   fifo_count <= fifo_count + CNT_ONE;
            2'b01:   fifo_count <= fifo_count - CNT_ONE;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Only reset clears the drop counter so starvation stays visible across flushes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         overflow_cnt <= '0;
      else if (drop && overflow_cnt != '1)
         overflow_cnt <= overflow_cnt + DROP_W'(1);
   end

endmodule

// File: tb/tb_lfsr_word_collector.sv
// Directed bench for lfsr_word_collector: assembly, divider, overflow, collision,
// enable/flush and asynchronous reset, with hand-computed expected words.
module tb_lfsr_word_collector;

   logic        clock, reset;
   logic        enable, flush, bit_in, out_ready;
   logic [12:0] out_data;
   logic        out_valid, busy;
   logic [2:0]  fifo_count;
   logic [7:0]  overflow_cnt;

   logic        en4, bit4;
   logic [12:0] data4;
   logic        valid4, busy4;
   logic [2:0]  count4;
   logic [7:0]  ovf4;

   int n_chk = 0;
   int n_err = 0;

   lfsr_word_collector dut (
      .clock(clock), .reset(reset), .enable(enable), .flush(flush), .bit_in(bit_in),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .fifo_count(fifo_count), .overflow_cnt(overflow_cnt), .busy(busy)
   );

   lfsr_word_collector #(.SAMPLE_DIV(4)) dut4 (
      .clock(clock), .reset(reset), .enable(en4), .flush(1'b0), .bit_in(bit4),
      .out_data(data4), .out_valid(valid4), .out_ready(1'b1),
      .fifo_count(count4), .overflow_cnt(ovf4), .busy(busy4)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_bit(input logic b);
      enable = 1'b1;
      bit_in = b;
      tick();
   endtask

   task automatic send_bits(input logic [12:0] w, input int first, input int n);
      for (int i = first; i < first + n; i++) send_bit(w[i]);
      enable = 1'b0;
   endtask

   task automatic send_word(input logic [12:0] w);
      send_bits(w, 0, 13);
   endtask

   task automatic expect_pops(input string tag, input logic [12:0] w);
      check({tag, "_valid"}, 32'(out_valid), 32'h1);
      check({tag, "_data"}, 32'(out_data), 32'(w));
      tick();
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; flush = 1'b0; bit_in = 1'b0; out_ready = 1'b0;
      en4 = 1'b0; bit4 = 1'b0;
      #12;
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_data", 32'(out_data), 32'h0);
      check("rst_count", 32'(fifo_count), 32'h0);
      check("rst_ovf", 32'(overflow_cnt), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      @(negedge clock);
      reset = 1'b1;
      tick();

      // divider: strobes on edges 4, 8, ... 52
      en4 = 1'b1; bit4 = 1'b1;
      repeat (51) tick();
      check("div_no_early", 32'(valid4), 32'h0);
      check("div_busy", 32'(busy4), 32'h1);
      tick();
      en4 = 1'b0;
      check("div_valid", 32'(valid4), 32'h1);
      check("div_data", 32'(data4), 32'h1FFF);
      tick();
      check("div_popped", 32'(count4), 32'h0);

      // empty pop is ignored
      out_ready = 1'b1;
      tick();
      check("empty_pop", 32'(fifo_count), 32'h0);

      // basic assembly, valid exactly one cycle after 13th sample edge
      send_bits(13'h1A5B, 0, 12);
      check("basic_not_yet", 32'(out_valid), 32'h0);
      send_bits(13'h1A5B, 12, 1);
      expect_pops("basic", 13'h1A5B);
      check("basic_drained", 32'(fifo_count), 32'h0);

      // overflow: fifth word dropped
      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) send_word(13'(k));
      check("ovf_count", 32'(fifo_count), 32'h4);
      check("ovf_cnt", 32'(overflow_cnt), 32'h1);
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) expect_pops("ovf_pop", 13'(k));
      check("ovf_no5", 32'(out_valid), 32'h0);

      // full push + pop on the same edge
      out_ready = 1'b0;
      send_word(13'h0101); send_word(13'h0202); send_word(13'h0303); send_word(13'h0404);
      send_bits(13'h0ABC, 0, 12);
      check("hold_data", 32'(out_data), 32'h0101);
      out_ready = 1'b1;
      send_bits(13'h0ABC, 12, 1);
      out_ready = 1'b0;
      check("coll_count", 32'(fifo_count), 32'h4);
      check("coll_ovf", 32'(overflow_cnt), 32'h1);
      out_ready = 1'b1;
      expect_pops("coll_a", 13'h0202);
      expect_pops("coll_b", 13'h0303);
      expect_pops("coll_c", 13'h0404);
      expect_pops("coll_d", 13'h0ABC);
      check("coll_empty", 32'(out_valid), 32'h0);

      // enable low freezes the partial word
      send_bits(13'h1234, 0, 6);
      repeat (20) tick();
      check("en_busy", 32'(busy), 32'h1);
      check("en_nopush", 32'(fifo_count), 32'h0);
      send_bits(13'h1234, 6, 7);
      expect_pops("en_word", 13'h1234);

      // flush discards the partial word but keeps overflow_cnt
      send_bits(13'h1FFF, 0, 6);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy", 32'(busy), 32'h0);
      send_word(13'h0555);
      expect_pops("flush_word", 13'h0555);
      check("flush_ovf", 32'(overflow_cnt), 32'h1);

      // asynchronous reset mid-operation
      out_ready = 1'b0;
      send_word(13'h0011); send_word(13'h0022);
      send_bits(13'h1FFF, 0, 7);
      check("pre_rst_count", 32'(fifo_count), 32'h2);
      #2 reset = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'h0);
      check("arst_count", 32'(fifo_count), 32'h0);
      check("arst_ovf", 32'(overflow_cnt), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      @(negedge clock);
      reset = 1'b1;
      tick();
      out_ready = 1'b1;
      send_bits(13'h0A0A, 0, 12);
      check("fresh_not_yet", 32'(out_valid), 32'h0);
      send_bits(13'h0A0A, 12, 1);
      expect_pops("fresh_word", 13'h0A0A);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
